// File: rtl/bcd_serial_adder_ctrl_pkg.sv
// bcd_serial_adder_ctrl_pkg
// Purpose: shared types and constants for the serial packed-BCD adder.
//   state_e         controller FSM states
//   DIGIT_W         width of one BCD digit
//   BCD_MAX         largest legal BCD digit value
//   BCD_ADJ         decimal correction added when a digit sum exceeds BCD_MAX
//   nibble_invalid  returns 1 when a nibble is not a legal BCD digit
package bcd_serial_adder_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CHECK = 2'd1,
    ST_ADD   = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam int          DIGIT_W = 4;
  localparam logic [3:0]  BCD_MAX = 4'd9;
  localparam logic [3:0]  BCD_ADJ = 4'd6;

  function automatic logic nibble_invalid(input logic [DIGIT_W-1:0] nib);
    return (nib > BCD_MAX);
  endfunction

endpackage

// File: rtl/bcd_serial_adder_ctrl_if.sv
// bcd_serial_adder_ctrl_if
// Purpose: handshake and operand/result bundle of the serial BCD adder.
//   start            request pulse/level from the operand-entry side
//   a, b             packed BCD operands, digit 0 in the low nibble
//   busy, done       operation in progress / one-cycle completion pulse
//   sum, carry_out   packed BCD result and decimal carry of the top digit
//   err_a, err_b     operand contained a nibble greater than nine
// Modports: master drives the request side, slave is the adder.
interface bcd_serial_adder_ctrl_if #(
  parameter int DIGITS = 4
);
  import bcd_serial_adder_ctrl_pkg::*;

  logic                      start;
  logic [DIGIT_W*DIGITS-1:0] a;
  logic [DIGIT_W*DIGITS-1:0] b;
  logic                      busy;
  logic                      done;
  logic [DIGIT_W*DIGITS-1:0] sum;
  logic                      carry_out;
  logic                      err_a;
  logic                      err_b;

  modport master (
    output start, a, b,
    input  busy, done, sum, carry_out, err_a, err_b
  );

  modport slave (
    input  start, a, b,
    output busy, done, sum, carry_out, err_a, err_b
  );

endinterface

// File: rtl/bcd_serial_adder_ctrl_digit_add.sv
// bcd_digit_add
// Purpose: combinational single-digit decimal adder with +6 correction.
//   dig_a, dig_b   input BCD digits
//   carry_in       decimal carry from the next lower digit
//   dig_sum        corrected BCD digit
//   carry_out      decimal carry into the next higher digit
module bcd_digit_add
  import bcd_serial_adder_ctrl_pkg::*;
(
  input  logic [DIGIT_W-1:0] dig_a,
  input  logic [DIGIT_W-1:0] dig_b,
  input  logic               carry_in,
  output logic [DIGIT_W-1:0] dig_sum,
  output logic               carry_out
);

  logic [DIGIT_W:0] raw_sum;
  logic [DIGIT_W:0] adj_sum;

  // The raw binary sum is kept one bit wider so 9+9+1 = 19 does not wrap
  // before the decimal comparison. Adding six skips the six unused codes
  // 10..15, so the low nibble of the adjusted value is the decimal digit.
  always_comb begin
    raw_sum   = {1'b0, dig_a} + {1'b0, dig_b} + {{DIGIT_W{1'b0}}, carry_in};
    adj_sum   = raw_sum + {1'b0, BCD_ADJ};
    dig_sum   = raw_sum[DIGIT_W-1:0];
    carry_out = 1'b0;
    if (raw_sum > {1'b0, BCD_MAX}) begin
      dig_sum   = adj_sum[DIGIT_W-1:0];
      carry_out = 1'b1;
    end
  end

endmodule

// File: rtl/bcd_serial_adder_ctrl.sv
// bcd_serial_adder_ctrl
// Purpose: multi-digit packed-BCD adder that validates both operands and then
//   feeds one digit pair per clock, least significant first, through a single
//   bcd_digit_add instance.
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset, aborts any operation
//   bus    slave side of bcd_serial_adder_ctrl_if (start/a/b in,
//          busy/done/sum/carry_out/err_a/err_b out)
module bcd_serial_adder_ctrl
  import bcd_serial_adder_ctrl_pkg::*;
#(
  parameter int DIGITS = 4
)(
  input  logic                   clk,
  input  logic                   rst_n,
  bcd_serial_adder_ctrl_if.slave bus
);

  localparam int W     = DIGIT_W * DIGITS;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  state_e             state_q, state_d;
  logic [W-1:0]       a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               carry_q, carry_d;
  logic               carry_out_q, carry_out_d;
  logic               err_a_q, err_a_d, err_b_q, err_b_d;
  logic               busy_q, busy_d, done_q, done_d;

  logic [DIGIT_W-1:0] cur_a, cur_b, dig_sum;
  logic               dig_carry;
  logic               bad_a, bad_b;

  // Select the digit pair addressed by the current index and flag any latched
  // nibble that is not a legal BCD digit.
  always_comb begin
    cur_a = '0;
    cur_b = '0;
    bad_a = 1'b0;
    bad_b = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        cur_a = a_q[i*DIGIT_W +: DIGIT_W];
        cur_b = b_q[i*DIGIT_W +: DIGIT_W];
      end
      bad_a = bad_a | nibble_invalid(a_q[i*DIGIT_W +: DIGIT_W]);
      bad_b = bad_b | nibble_invalid(b_q[i*DIGIT_W +: DIGIT_W]);
    end
  end

  bcd_digit_add u_digit_add (
    .dig_a     (cur_a),
    .dig_b     (cur_b),
    .carry_in  (carry_q),
    .dig_sum   (dig_sum),
    .carry_out (dig_carry)
  );

  // Sequencer next-state logic. busy and done are computed one cycle ahead so
  // they come straight from flops: busy rises with the accepting edge and
  // falls with the edge that leaves DONE, done is set only on entry to DONE.
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    sum_d       = sum_q;
    idx_d       = idx_q;
    carry_d     = carry_q;
    carry_out_d = carry_out_q;
    err_a_d     = err_a_q;
    err_b_d     = err_b_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          a_d         = bus.a;
          b_d         = bus.b;
          sum_d       = '0;
          idx_d       = '0;
          carry_d     = 1'b0;
          carry_out_d = 1'b0;
          err_a_d     = 1'b0;
          err_b_d     = 1'b0;
          busy_d      = 1'b1;
          state_d     = ST_CHECK;
        end
      end
      ST_CHECK: begin
        err_a_d = bad_a;
        err_b_d = bad_b;
        idx_d   = '0;
        carry_d = 1'b0;
        if (bad_a || bad_b) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end else begin
          state_d = ST_ADD;
        end
      end
      ST_ADD: begin
        for (int i = 0; i < DIGITS; i++) begin
          if (idx_q == IDX_W'(i)) begin
            sum_d[i*DIGIT_W +: DIGIT_W] = dig_sum;
          end
        end
        carry_d = dig_carry;
        if (idx_q == IDX_W'(DIGITS - 1)) begin
          carry_out_d = dig_carry;
          state_d     = ST_DONE;
          done_d      = 1'b1;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      ST_DONE: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset clears everything so an abort leaves
  // all outputs at zero with no completion pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      idx_q       <= '0;
      carry_q     <= 1'b0;
      carry_out_q <= 1'b0;
      err_a_q     <= 1'b0;
      err_b_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sum_q       <= sum_d;
      idx_q       <= idx_d;
      carry_q     <= carry_d;
      carry_out_q <= carry_out_d;
      err_a_q     <= err_a_d;
      err_b_q     <= err_b_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.sum       = sum_q;
  assign bus.carry_out = carry_out_q;
  assign bus.err_a     = err_a_q;
  assign bus.err_b     = err_b_q;

endmodule

// File: tb/tb_bcd_serial_adder_ctrl.sv
// tb_bcd_serial_adder_ctrl
// Purpose: self-checking bench for bcd_serial_adder_ctrl with DIGITS=4.
//   Directed vectors from a table, randomized operands against a decimal
//   reference model, and hand-written sequences for busy-start, mid-operation
//   reset and back-to-back operation.
module tb_bcd_serial_adder_ctrl;

  localparam int DIGITS = 4;
  localparam int W      = 4 * DIGITS;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp_sum;
    logic         exp_carry;
    logic         exp_err_a;
    logic         exp_err_b;
  } vec_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  bcd_serial_adder_ctrl_if #(.DIGITS(DIGITS)) bus ();

  bcd_serial_adder_ctrl #(.DIGITS(DIGITS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Free-running clock, 10 time units per cycle.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One comparison: counted, and reported only when it disagrees.
  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  // Decimal reference: operands are read as decimal numbers, added, and the
  // result is re-encoded; any nibble above nine makes the operand invalid.
  function automatic void refModel(input logic [W-1:0] av, input logic [W-1:0] bv,
                                   output logic [W-1:0] s, output logic c,
                                   output logic ea, output logic eb);
    int va, vb, p, tot;
    logic [3:0] na, nb;
    va = 0; vb = 0; p = 1; ea = 1'b0; eb = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      na = av[i*4 +: 4];
      nb = bv[i*4 +: 4];
      if (na > 9) ea = 1'b1;
      if (nb > 9) eb = 1'b1;
      va = va + int'(na) * p;
      vb = vb + int'(nb) * p;
      p  = p * 10;
    end
    s = '0;
    c = 1'b0;
    if (!(ea || eb)) begin
      tot = va + vb;
      c   = (tot >= p);
      tot = tot % p;
      for (int i = 0; i < DIGITS; i++) begin
        s[i*4 +: 4] = 4'(tot % 10);
        tot = tot / 10;
      end
    end
  endfunction

  // Issue one operation, scramble the operand inputs after acceptance, then
  // wait (bounded) for done and check latency, busy, result and flags.
  task automatic applyStimulus(input logic [W-1:0] av, input logic [W-1:0] bv,
                               input logic [W-1:0] exp_sum, input logic exp_c,
                               input logic exp_ea, input logic exp_eb, input string name);
    int   k;
    int   exp_lat;
    logic busy_ok;
    exp_lat = (exp_ea || exp_eb) ? 2 : DIGITS + 2;
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = av;
    bus.b     = bv;
    @(negedge clk);
    bus.start = 1'b0;
    bus.a     = W'($urandom);
    bus.b     = W'($urandom);
    k = 0;
    busy_ok = 1'b1;
    while (!bus.done && k < 20) begin
      busy_ok = busy_ok & bus.busy;
      @(negedge clk);
      k++;
    end
    checkOutput({name, " done_seen"}, 32'(bus.done), 32'd1);
    checkOutput({name, " latency"}, 32'(k + 1), 32'(exp_lat));
    checkOutput({name, " busy"}, 32'(busy_ok & bus.busy), 32'd1);
    checkOutput({name, " sum"}, 32'(bus.sum), 32'(exp_sum));
    checkOutput({name, " carry_out"}, 32'(bus.carry_out), 32'(exp_c));
    checkOutput({name, " err_a"}, 32'(bus.err_a), 32'(exp_ea));
    checkOutput({name, " err_b"}, 32'(bus.err_b), 32'(exp_eb));
    @(negedge clk);
    checkOutput({name, " idle done"}, 32'(bus.done), 32'd0);
    checkOutput({name, " idle busy"}, 32'(bus.busy), 32'd0);
    checkOutput({name, " held sum"}, 32'(bus.sum), 32'(exp_sum));
  endtask

  // Random operand: legal digits, with an occasional illegal nibble planted.
  function automatic logic [W-1:0] randOperand();
    logic [W-1:0] v;
    v = '0;
    for (int i = 0; i < DIGITS; i++) v[i*4 +: 4] = 4'($urandom_range(0, 9));
    if ($urandom_range(0, 5) == 0) v[$urandom_range(0, DIGITS-1)*4 +: 4] = 4'($urandom_range(10, 15));
    return v;
  endfunction

  vec_t vecs[8];

  initial begin
    logic [W-1:0] rs, ra, rb;
    logic         rc, rea, reb;
    int           k, ndone, first_k;
    int           done_k[2];
    logic [W-1:0] done_sum[2];
    logic         done_c[2];
    logic         busy_ok;

    checks   = 0;
    failures = 0;

    vecs[0] = '{16'h1234, 16'h5678, 16'h6912, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{16'h9999, 16'h0001, 16'h0000, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{16'h0505, 16'h0505, 16'h1010, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{16'h12A4, 16'h0003, 16'h0000, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{16'hF000, 16'hFFFF, 16'h0000, 1'b0, 1'b1, 1'b1};
    vecs[5] = '{16'h9999, 16'h9999, 16'h9998, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0};
    vecs[7] = '{16'h0042, 16'h0058, 16'h0100, 1'b0, 1'b0, 1'b0};

    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset busy", 32'(bus.busy), 32'd0);
    checkOutput("reset done", 32'(bus.done), 32'd0);
    checkOutput("reset sum", 32'(bus.sum), 32'd0);
    checkOutput("reset flags", {29'd0, bus.carry_out, bus.err_a, bus.err_b}, 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i].a, vecs[i].b, vecs[i].exp_sum, vecs[i].exp_carry,
                    vecs[i].exp_err_a, vecs[i].exp_err_b, $sformatf("vec%0d", i));
    end

    for (int i = 0; i < 30; i++) begin
      ra = randOperand();
      rb = randOperand();
      refModel(ra, rb, rs, rc, rea, reb);
      applyStimulus(ra, rb, rs, rc, rea, reb, $sformatf("rand%0d", i));
    end

    // Start while busy: the second request two cycles in must be dropped.
    @(negedge clk);
    bus.start = 1'b1; bus.a = 16'h1234; bus.b = 16'h5678;
    ndone = 0; first_k = -1; busy_ok = 1'b1; rs = '0;
    for (k = 0; k < 16; k++) begin
      @(negedge clk);
      bus.start = (k == 2);
      if (k == 2) begin bus.a = 16'h1111; bus.b = 16'h2222; end
      if (first_k < 0) busy_ok = busy_ok & bus.busy;
      if (bus.done) begin
        ndone++;
        if (first_k < 0) begin first_k = k; rs = bus.sum; end
      end
    end
    bus.start = 1'b0;
    checkOutput("busy_start done_count", 32'(ndone), 32'd1);
    checkOutput("busy_start latency", 32'(first_k + 1), 32'(DIGITS + 2));
    checkOutput("busy_start sum", 32'(rs), 32'h6912);
    checkOutput("busy_start busy_continuous", 32'(busy_ok), 32'd1);

    // Reset in the middle of ADD: outputs drop at once and no done follows.
    @(negedge clk);
    bus.start = 1'b1; bus.a = 16'h1234; bus.b = 16'h5678;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("abort busy", 32'(bus.busy), 32'd0);
    checkOutput("abort done", 32'(bus.done), 32'd0);
    checkOutput("abort sum", 32'(bus.sum), 32'd0);
    checkOutput("abort flags", {29'd0, bus.carry_out, bus.err_a, bus.err_b}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (k = 0; k < 10; k++) begin
      @(negedge clk);
      if (bus.done) ndone++;
    end
    checkOutput("abort no_done", 32'(ndone), 32'd0);
    applyStimulus(16'h0042, 16'h0058, 16'h0100, 1'b0, 1'b0, 1'b0, "after_abort");

    // Back-to-back: start held high; operands change right after acceptance
    // and must only be taken at the next accepting edge.
    @(negedge clk);
    bus.start = 1'b1; bus.a = 16'h0123; bus.b = 16'h0877;
    ndone = 0;
    for (k = 0; k < 30 && ndone < 2; k++) begin
      @(negedge clk);
      if (k == 0) begin bus.a = 16'h4567; bus.b = 16'h5433; end
      if (bus.done) begin
        done_k[ndone]   = k;
        done_sum[ndone] = bus.sum;
        done_c[ndone]   = bus.carry_out;
        ndone++;
        if (ndone == 2) bus.start = 1'b0;
      end
    end
    bus.start = 1'b0;
    checkOutput("b2b done_count", 32'(ndone), 32'd2);
    if (ndone == 2) begin
      checkOutput("b2b first_latency", 32'(done_k[0] + 1), 32'(DIGITS + 2));
      checkOutput("b2b spacing", 32'(done_k[1] - done_k[0]), 32'(DIGITS + 3));
      refModel(16'h0123, 16'h0877, rs, rc, rea, reb);
      checkOutput("b2b sum0", 32'(done_sum[0]), 32'(rs));
      checkOutput("b2b carry0", 32'(done_c[0]), 32'(rc));
      refModel(16'h4567, 16'h5433, rs, rc, rea, reb);
      checkOutput("b2b sum1", 32'(done_sum[1]), 32'(rs));
      checkOutput("b2b carry1", 32'(done_c[1]), 32'(rc));
    end
    repeat (4) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bcd_serial_adder_ctrl.md
# bcd_serial_adder_ctrl

Sequencer that adds two multi-digit packed-BCD operands by running one 4-bit digit pair per clock through a single-digit decimal adder with +6 correction and ripple carry. Before adding, it validates every input digit (nibble > 9 is an error) and reports per-operand error flags instead of a result. It sits between the operand-entry logic and the display/result path, turning the single-digit add-and-correct datapath into a handshaken multi-digit unit.

## Interface
- DIGITS, 4, number of BCD digits per operand (≥1)
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request; sampled only in IDLE
- a  in  4*DIGITS  operand A, packed BCD, digit 0 in bits [3:0]
- b  in  4*DIGITS  operand B, same packing
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle completion pulse
- sum  out  4*DIGITS  packed BCD result, held until next accepted start
- carry_out  out  1  decimal carry out of the top digit
- err_a  out  1  A contained a nibble > 9
- err_b  out  1  B contained a nibble > 9

## Operation
- States: IDLE, CHECK, ADD, DONE.
- IDLE: start=1 latches a and b into internal registers, clears sum, carry_out, err_a, err_b and the digit index, and moves to CHECK.
- CHECK, one cycle: err_a is set if any latched A nibble > 9; err_b likewise for B. If either is set, go to DONE with sum=0 and carry_out=0. Otherwise go to ADD with carry=0 and index=0.
- ADD, one digit per cycle, LSD first:
  - t = a_i + b_i + carry, computed 5 bits wide.
  - If t > 9: digit = (t + 6)[3:0] and carry = 1. Otherwise digit = t[3:0] and carry = 0.
  - The digit is written into sum[4i+3:4i].
  - After index DIGITS-1: carry_out = carry, go to DONE.
- DONE, one cycle: done=1, then return to IDLE.
- Ignored inputs:
  - start outside IDLE is ignored; there is no queueing.
  - a and b changes after acceptance are ignored.
- sum, carry_out, err_a and err_b hold their values in IDLE until the next accepted start.

## Timing
- Reset value of every output: 0. The FSM resets to IDLE and the internal registers reset to 0.
- Reset asserted mid-operation aborts immediately. No done pulse is generated.
- The start-sampling edge is edge 0.
- busy is high from edge 0 until the edge that leaves DONE, so busy and done are both high during the DONE cycle.
- Valid operands: done is high in the cycle after edge DIGITS+1, i.e. latency DIGITS+2 cycles (6 for DIGITS=4).
- Invalid operands: done is high in the cycle after edge 1, i.e. latency 2 cycles.
- Back-to-back operation: start held high in the cycle after DONE begins a new operation; the minimum issue interval is DIGITS+3 cycles.
- Error flags and sum are stable whenever done=1.

## Structure
- Shared package: FSM state enum, the BCD_MAX=9 and BCD_ADJ=6 constants, and the DIGIT_W=4 width constant.
- Sub-module `bcd_digit_add` is purely combinational:
  - inputs: two digits and carry-in
  - outputs: corrected digit and carry-out
  - instantiated once, with the controller muxing the digit by index.
- Digit-validity check: inline reduction over nibbles in the controller, or a small function in the package.

## Test plan
- Normal sum, DIGITS=4: a=0x1234, b=0x5678, start pulse -> done 6 cycles later with sum=0x6912, carry_out=0, err_a=err_b=0.
- Full carry ripple: a=0x9999, b=0x0001 -> sum=0x0000, carry_out=1. A second case, a=0x0505, b=0x0505, -> sum=0x1010, carry_out=0.
- Operand error: a=0x12A4, b=0x0003 -> done 2 cycles after start with err_a=1, err_b=0, sum=0. A second case, a=0xF000, b=0xFFFF, -> err_a=1, err_b=1.
- Start while busy: assert start again 2 cycles into an operation with different operands -> ignored. The single done carries the first operation's result; busy stays continuous.
- Reset mid-ADD: assert rst_n=0 at cycle 3 -> all outputs 0 immediately and no done pulse. A fresh start after release of 0x0042 + 0x0058 -> sum=0x0100, carry_out=0.
- Back-to-back: start held high -> consecutive done pulses spaced 7 cycles apart, each with the correct sum for the operands latched at its own acceptance.
